// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered 32-bit ALU between
// NUM_REQ requesters, with valid/ready handshakes on the request and
// response sides.
// Optional statistics counters (op_count, busy_cycles) are compiled in when
// the macro ALU_ARB_STATS_EN is defined.

module alu_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [31:0]             resp_data,
  output logic                    resp_zero,
  output logic                    resp_err,
  output logic [3:0]              alu_control_signal,
  output logic [31:0]             alu_in0,
  output logic [31:0]             alu_in1,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  output logic                    busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]             op_count,
  output logic [31:0]             busy_cycles
`endif
);

  localparam int unsigned PTR_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_LAST = ALU_LATENCY + 1;
  localparam int unsigned CNT_W    = $clog2(CNT_LAST + 1);
  localparam logic [3:0]  OP_MAX   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   rr_ptr_d;
  logic [PTR_W-1:0]   owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [31:0]        resp_data_q;
  logic               resp_zero_q;
  logic               resp_err_q;
  logic [3:0]         alu_ctrl_q;
  logic [31:0]        alu_in0_q;
  logic [31:0]        alu_in1_q;

  logic [3:0]         op_arr [NUM_REQ];
  logic [31:0]        a_arr  [NUM_REQ];
  logic [31:0]        b_arr  [NUM_REQ];

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] owner_oh;
  logic [3:0]         win_op;
  logic [31:0]        win_a;
  logic [31:0]        win_b;
  logic               accept;
  logic               resp_hs;
  logic               exec_done;

  // Unpack the flat per-requester buses into indexable arrays
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[4*gi +: 4];
    assign a_arr[gi]  = req_a[32*gi +: 32];
    assign b_arr[gi]  = req_b[32*gi +: 32];
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && req_valid[PTR_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  // Winner decode, handshake qualifiers and next pointer/counter values
  always_comb begin
    grant_oh  = NUM_REQ'(1) << grant_idx;
    owner_oh  = NUM_REQ'(1) << owner_q;
    win_op    = op_arr[grant_idx];
    win_a     = a_arr[grant_idx];
    win_b     = b_arr[grant_idx];
    accept    = (state_q == ST_IDLE) && grant_found;
    resp_hs   = (state_q == ST_RESP) && (|(resp_ready & owner_oh));
    exec_done = (cnt_q == CNT_W'(CNT_LAST));
    rr_ptr_d  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
    cnt_d     = cnt_q + CNT_W'(1);
  end

  // Ready is combinational so a requester sees its grant in the same cycle
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found) begin
      req_ready = grant_oh;
    end
  end

  // Control FSM; the ALU drive registers double as the operation holding
  // registers and are only non-zero while in EXEC
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      alu_ctrl_q   <= '0;
      alu_in0_q    <= '0;
      alu_in1_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q  <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            if (win_op <= OP_MAX) begin
              state_q    <= ST_EXEC;
              cnt_q      <= '0;
              alu_ctrl_q <= win_op;
              alu_in0_q  <= win_a;
              alu_in1_q  <= win_b;
            end else begin
              // Unsupported opcode: answer at once with an error, ALU untouched
              state_q      <= ST_RESP;
              resp_valid_q <= grant_oh;
              resp_data_q  <= '0;
              resp_zero_q  <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            state_q      <= ST_RESP;
            resp_valid_q <= owner_oh;
            resp_data_q  <= alu_result;
            resp_zero_q  <= alu_zero;
            resp_err_q   <= 1'b0;
            alu_ctrl_q   <= '0;
            alu_in0_q    <= '0;
            alu_in1_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          if (resp_hs) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= '0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= '0;
          alu_ctrl_q   <= '0;
          alu_in0_q    <= '0;
          alu_in1_q    <= '0;
        end
      endcase
    end
  end

  assign resp_valid         = resp_valid_q;
  assign resp_data          = resp_data_q;
  assign resp_zero          = resp_zero_q;
  assign resp_err           = resp_err_q;
  assign alu_control_signal = alu_ctrl_q;
  assign alu_in0            = alu_in0_q;
  assign alu_in1            = alu_in1_q;
  assign busy               = (state_q != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [31:0] op_count_q;
  logic [31:0] busy_cycles_q;

  // Saturating counters of completed operations and non-idle cycles
  always_ff @(posedge clk) begin
    if (clear) begin
      op_count_q    <= '0;
      busy_cycles_q <= '0;
    end else begin
      if (resp_hs && (op_count_q != 32'hFFFF_FFFF)) begin
        op_count_q <= op_count_q + 32'd1;
      end
      if (busy && (busy_cycles_q != 32'hFFFF_FFFF)) begin
        busy_cycles_q <= busy_cycles_q + 32'd1;
      end
    end
  end

  assign op_count    = op_count_q;
  assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (NUM_REQ=4, ALU_LATENCY=1) with a small
// registered ALU stand-in driving alu_result/alu_zero.

module tb_alu_arbiter;

  logic         clk = 1'b0;
  logic         clear;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [31:0]  resp_data;
  logic         resp_zero;
  logic         resp_err;
  logic [3:0]   alu_control_signal;
  logic [31:0]  alu_in0;
  logic [31:0]  alu_in1;
  logic [31:0]  alu_result;
  logic         alu_zero;
  logic         busy;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]  op_count;
  logic [31:0]  busy_cycles;
`endif

  logic [3:0]   tb_op [4];
  logic [31:0]  tb_a  [4];
  logic [31:0]  tb_b  [4];

  int checks = 0;
  int errors = 0;

  assign req_op = {tb_op[3], tb_op[2], tb_op[1], tb_op[0]};
  assign req_a  = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
  assign req_b  = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};

  alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(1)) dut (
    .clk                (clk),
    .clear              (clear),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_a              (req_a),
    .req_b              (req_b),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_data          (resp_data),
    .resp_zero          (resp_zero),
    .resp_err           (resp_err),
    .alu_control_signal (alu_control_signal),
    .alu_in0            (alu_in0),
    .alu_in1            (alu_in1),
    .alu_result         (alu_result),
    .alu_zero           (alu_zero),
    .busy               (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_count           (op_count),
    .busy_cycles        (busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      default: return 32'd0;
    endcase
  endfunction

  // One-cycle registered ALU stand-in
  always @(posedge clk) begin
    alu_result <= alu_f(alu_control_signal, alu_in0, alu_in1);
    alu_zero   <= (alu_f(alu_control_signal, alu_in0, alu_in1) == 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int     nexp;
    int     guard;
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    clear      = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tb_op[i] = 4'd0;
      tb_a[i]  = 32'd0;
      tb_b[i]  = 32'd0;
    end
    step();
    step();

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_control_signal), 32'd0);
    chk("rst_alu_in0", alu_in0, 32'd0);
    clear = 1'b0;

    // Single request: req0 add 5+7
    tb_op[0] = 4'd0; tb_a[0] = 32'd5; tb_b[0] = 32'd7;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    step();                                     // T0
    req_valid = 4'b0000;
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_alu_ctrl", 32'(alu_control_signal), 32'd0);
    chk("single_alu_in0", alu_in0, 32'd5);
    chk("single_alu_in1", alu_in1, 32'd7);
    step();                                     // T0+1
    step();                                     // T0+2
    chk("single_valid_early", 32'(resp_valid), 32'd0);
    step();                                     // T0+3
    chk("single_valid", 32'(resp_valid), 32'h1);
    chk("single_data", resp_data, 32'd12);
    chk("single_zero", 32'(resp_zero), 32'd0);
    chk("single_err", 32'(resp_err), 32'd0);
    chk("single_alu_off", 32'(alu_in0), 32'd0);
    step();                                     // response handshake
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_valid_drop", 32'(resp_valid), 32'd0);

    // Zero flag: req2 subtract equal operands
    tb_op[2] = 4'd1; tb_a[2] = 32'h1234; tb_b[2] = 32'h1234;
    req_valid = 4'b0100;
    #1;
    chk("zero_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    step(); step(); step();
    chk("zero_valid", 32'(resp_valid), 32'h4);
    chk("zero_data", resp_data, 32'd0);
    chk("zero_flag", 32'(resp_zero), 32'd1);
    step();
    chk("zero_idle", 32'(busy), 32'd0);

    // Illegal opcode from req3, response held with resp_ready low
    tb_op[3] = 4'b1100; tb_a[3] = 32'hDEAD; tb_b[3] = 32'hBEEF;
    resp_ready = 4'b0111;
    req_valid  = 4'b1000;
    #1;
    chk("ill_ready", 32'(req_ready), 32'h8);
    step();                                     // T0
    req_valid = 4'b0000;
    chk("ill_alu_ctrl_t0", 32'(alu_control_signal), 32'd0);
    step();                                     // T0+1
    chk("ill_valid", 32'(resp_valid), 32'h8);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_data", resp_data, 32'd0);
    chk("ill_zero", 32'(resp_zero), 32'd1);
    chk("ill_alu_ctrl", 32'(alu_control_signal), 32'd0);
    chk("ill_alu_in0", alu_in0, 32'd0);
    resp_ready = 4'b1111;
    step();
    chk("ill_idle", 32'(busy), 32'd0);

    // Fairness: all four requesters continuously valid, pointer now at 0
    for (int i = 0; i < 4; i++) begin
      tb_op[i] = 4'd2;
      tb_a[i]  = 32'hFF00 + 32'(i);
      tb_b[i]  = 32'h0F0F;
    end
    req_valid = 4'b1111;
    #1;
    nexp  = 0;
    guard = 0;
    while (nexp < 5 && guard < 60) begin
      chk("fair_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (req_ready != 4'b0000) begin
        chk("fair_order", 32'(req_ready), 32'(order[nexp]));
        nexp++;
      end
      if (nexp < 5) begin
        step();
        guard++;
      end
    end
    chk("fair_grants", 32'(nexp), 32'd5);
    step();                                     // accept of the fifth grant
    req_valid = 4'b0000;
    wait_idle("fair_finish");

    // Backpressure: req1 response held off for five cycles, req0 waiting
    tb_op[1] = 4'd3; tb_a[1] = 32'h00F0; tb_b[1] = 32'h000F;
    tb_op[0] = 4'd0; tb_a[0] = 32'd1;    tb_b[0] = 32'd2;
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    #1;
    chk("bp_ready", 32'(req_ready), 32'h2);
    step();                                     // T0
    req_valid = 4'b0001;
    step(); step(); step();
    chk("bp_valid", 32'(resp_valid), 32'h2);
    chk("bp_data", resp_data, 32'h00FF);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 32'(resp_valid), 32'h2);
      chk("bp_hold_data", resp_data, 32'h00FF);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 4'b1111;
    step();
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_valid_drop", 32'(resp_valid), 32'd0);
    chk("bp_next_ready", 32'(req_ready), 32'h1);
    step();                                     // req0 accepted
    req_valid = 4'b0000;
    step(); step(); step();
    chk("bp_req0_valid", 32'(resp_valid), 32'h1);
    chk("bp_req0_data", resp_data, 32'd3);
    step();
    chk("bp_req0_idle", 32'(busy), 32'd0);

    // Reset one cycle into EXEC discards req2's operation
    tb_op[2] = 4'd0; tb_a[2] = 32'd9; tb_b[2] = 32'd9;
    req_valid = 4'b0100;
    #1;
    chk("clr_ready", 32'(req_ready), 32'h4);
    step();                                     // T0
    req_valid = 4'b0000;
    step();                                     // one cycle into EXEC
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_resp_valid", 32'(resp_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_alu_ctrl", 32'(alu_control_signal), 32'd0);
    chk("clr_alu_in0", alu_in0, 32'd0);
    chk("clr_alu_in1", alu_in1, 32'd0);
    chk("clr_resp_data", resp_data, 32'd0);
    chk("clr_resp_err", 32'(resp_err), 32'd0);
    chk("clr_resp_zero", 32'(resp_zero), 32'd0);
    chk("clr_req_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("clr_no_resp", 32'(resp_valid), 32'd0);
    end
    tb_op[1] = 4'd0; tb_a[1] = 32'd4; tb_b[1] = 32'd4;
    tb_op[3] = 4'd0; tb_a[3] = 32'd6; tb_b[3] = 32'd6;
    req_valid = 4'b1010;
    #1;
    chk("clr_ptr_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    step(); step(); step();
    chk("clr_after_valid", 32'(resp_valid), 32'h2);
    chk("clr_after_data", resp_data, 32'd8);
    step();
    chk("clr_after_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
